fetch_pc_ctrl: RTL and testbench

Fetch-side PC controller and prediction tracker sitting directly upstream of the branch target buffer. It owns the program counter and drives the BTB lookup PC (stage 1). It carries each fetched instruction's PC and predicted-taken bit through the IF/ID and ID/EX registers so the BTB receives a consistent stage-3 view (`instructionPC_3`, `prev_taken_3`, `is_branchInst_3`). It applies the BTB's next-PC/flush decision and handles memory and load-use stalls.

---
 rtl/fetch_pc_ctrl_pkg.sv | 27 ++
 rtl/fetch_pc_ctrl_if.sv | 34 +++
 rtl/fetch_pc_ctrl_stage_reg.sv | 29 ++
 rtl/fetch_pc_ctrl.sv | 54 +++++
 tb/tb_fetch_pc_ctrl.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared types and constants for the fetch PC controller: reset/bubble values
// and the pipeline slot layouts carried towards the BTB.
package fetch_pkg;
  localparam int          XLEN      = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            pred;
    logic            valid;
  } if_id_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            pred;
    logic            is_branch;
    logic            valid;
  } id_ex_t;

  // A bubble rewrites only the masked fields, to their reset values; pc is kept.
  localparam if_id_t IF_RST      = '{pc: RESET_PC, instr: NOP_INSTR, pred: 1'b0, valid: 1'b0};
  localparam if_id_t IF_BUB_MASK = '{pc: '0, instr: '1, pred: 1'b1, valid: 1'b1};
  localparam id_ex_t EX_RST      = '{pc: RESET_PC, pred: 1'b0, is_branch: 1'b0, valid: 1'b0};
  localparam id_ex_t EX_BUB_MASK = '{pc: '0, pred: 1'b1, is_branch: 1'b1, valid: 1'b1};
endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// Fetch-side bus: icache port, BTB request/response and the stage-2/3 view.
interface fetch_pc_ctrl_if;
  import fetch_pkg::*;
  logic            memory_stall;
  logic            load_use_stall;
  logic [XLEN-1:0] btb_branchPC;
  logic            btb_flush;
  logic            btb_taken;
  logic [31:0]     icache_rdata;
  logic            is_branch_2;
  logic [XLEN-1:0] icache_addr;
  logic            icache_ren;
  logic [XLEN-1:0] instructionPC_1;
  logic [XLEN-1:0] pc_2;
  logic [31:0]     instr_2;
  logic            valid_2;
  logic [XLEN-1:0] instructionPC_3;
  logic            prev_taken_3;
  logic            is_branchInst_3;
  logic            valid_3;

  modport master (
    input  memory_stall, load_use_stall, btb_branchPC, btb_flush, btb_taken,
           icache_rdata, is_branch_2,
    output icache_addr, icache_ren, instructionPC_1, pc_2, instr_2, valid_2,
           instructionPC_3, prev_taken_3, is_branchInst_3, valid_3
  );
  modport slave (
    output memory_stall, load_use_stall, btb_branchPC, btb_flush, btb_taken,
           icache_rdata, is_branch_2,
    input  icache_addr, icache_ren, instructionPC_1, pc_2, instr_2, valid_2,
           instructionPC_3, prev_taken_3, is_branchInst_3, valid_3
  );
endinterface

// File: rtl/fetch_pc_ctrl_stage_reg.sv
// Generic pipeline slot: hold beats bubble beats load; bubble resets masked fields.
module fetch_stage_reg #(
  parameter int           W        = 1,
  parameter logic [W-1:0] RST_VAL  = '0,
  parameter logic [W-1:0] BUB_MASK = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hold_i,
  input  logic         bubble_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] slot_q, slot_d;

  always_comb begin
    slot_d = slot_q;
    if (hold_i)        slot_d = slot_q;
    else if (bubble_i) slot_d = (slot_q & ~BUB_MASK) | (RST_VAL & BUB_MASK);
    else               slot_d = d_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) slot_q <= RST_VAL;
    else        slot_q <= slot_d;
  end

  assign q_o = slot_q;
endmodule

// File: rtl/fetch_pc_ctrl.sv
// PC owner and IF/ID, ID/EX prediction tracker feeding the BTB's stage-3 check.
module fetch_pc_ctrl
  import fetch_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  fetch_pc_ctrl_if.master bus
);
  logic [XLEN-1:0] pc_q, pc_d;
  logic            ren_q;
  if_id_t          if_d, if_q;
  id_ex_t          ex_d, ex_q;
  logic            hold_front, bub_front, hold_ex, bub_ex;

  // Flush wins over load-use: the stalled instruction is on the wrong path.
  assign hold_front = bus.memory_stall | (bus.load_use_stall & ~bus.btb_flush);
  assign bub_front  = bus.btb_flush;
  assign hold_ex    = bus.memory_stall;
  assign bub_ex     = bus.btb_flush | bus.load_use_stall;

  assign pc_d = hold_front ? pc_q : bus.btb_branchPC;
  assign if_d = '{pc: pc_q, instr: bus.icache_rdata, pred: bus.btb_taken, valid: 1'b1};
  assign ex_d = '{pc: if_q.pc, pred: if_q.pred, is_branch: bus.is_branch_2, valid: if_q.valid};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      ren_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ren_q <= 1'b1;
    end
  end

  fetch_stage_reg #(.W($bits(if_id_t)), .RST_VAL(IF_RST), .BUB_MASK(IF_BUB_MASK)) u_if_id (
    .clk(clk), .rst_n(rst_n), .hold_i(hold_front), .bubble_i(bub_front), .d_i(if_d), .q_o(if_q)
  );

  fetch_stage_reg #(.W($bits(id_ex_t)), .RST_VAL(EX_RST), .BUB_MASK(EX_BUB_MASK)) u_id_ex (
    .clk(clk), .rst_n(rst_n), .hold_i(hold_ex), .bubble_i(bub_ex), .d_i(ex_d), .q_o(ex_q)
  );

  assign bus.icache_addr     = pc_q;
  assign bus.instructionPC_1 = pc_q;
  assign bus.icache_ren      = ren_q;
  assign bus.pc_2            = if_q.pc;
  assign bus.instr_2         = if_q.instr;
  assign bus.valid_2         = if_q.valid;
  assign bus.instructionPC_3 = ex_q.pc;
  assign bus.valid_3         = ex_q.valid;
  // Qualified so a bubble can never look like a mispredicted branch to the BTB.
  assign bus.prev_taken_3    = ex_q.pred & ex_q.valid;
  assign bus.is_branchInst_3 = ex_q.is_branch & ex_q.valid;
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: directed vector table, reset checks, random run vs. model.
module tb_fetch_pc_ctrl;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_pc_ctrl_if bus();
  fetch_pc_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[31:2] ^ 30'h2AAA_5555, 2'b11};
  endfunction
  assign bus.icache_rdata = imem(bus.icache_addr);

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic mem, lu, fl, tk, br, input logic [31:0] tgt);
    bus.memory_stall   = mem;
    bus.load_use_stall = lu;
    bus.btb_flush      = fl;
    bus.btb_taken      = tk;
    bus.is_branch_2    = br;
    bus.btb_branchPC   = tgt;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".pc"},    bus.icache_addr, RESET_PC);
    chk({tag, ".pc1"},   bus.instructionPC_1, RESET_PC);
    chk({tag, ".ren"},   {31'd0, bus.icache_ren}, 32'd0);
    chk({tag, ".v2"},    {31'd0, bus.valid_2}, 32'd0);
    chk({tag, ".v3"},    {31'd0, bus.valid_3}, 32'd0);
    chk({tag, ".instr2"}, bus.instr_2, NOP_INSTR);
    chk({tag, ".pc2"},   bus.pc_2, RESET_PC);
    chk({tag, ".pc3"},   bus.instructionPC_3, RESET_PC);
    chk({tag, ".pt3"},   {31'd0, bus.prev_taken_3}, 32'd0);
    chk({tag, ".ib3"},   {31'd0, bus.is_branchInst_3}, 32'd0);
  endtask

  // Inputs for one cycle and the state expected after that cycle's edge.
  typedef struct {
    logic mem, lu, fl, tk, br;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic e_v2;
    logic [31:0] e_pc2;
    logic e_v3;
    logic [31:0] e_pc3;
    logic e_pt, e_ib;
  } vec_t;
  localparam int NV = 20;
  vec_t tv [NV];

  // Reference model: PC plus two in-flight slots, advanced by the priority rules.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic pred, br, valid;
  } slot_t;
  logic [31:0] m_pc;
  logic        m_ren;
  slot_t       m_s [2];

  task automatic m_reset();
    m_pc = RESET_PC;
    m_ren = 1'b0;
    for (int k = 0; k < 2; k++) m_s[k] = '{pc: RESET_PC, instr: NOP_INSTR, pred: 1'b0, br: 1'b0, valid: 1'b0};
  endtask

  task automatic m_step(input logic rst, mem, lu, fl, tk, br, input logic [31:0] tgt);
    slot_t bub;
    bub = '{pc: 32'h0, instr: NOP_INSTR, pred: 1'b0, br: 1'b0, valid: 1'b0};
    if (rst) begin m_reset(); return; end
    m_ren = 1'b1;
    if (mem) return;
    if (fl) begin
      bub.pc = m_s[0].pc; m_s[0] = bub;
      bub.pc = m_s[1].pc; m_s[1] = bub;
      m_pc = tgt;
    end else if (lu) begin
      bub.pc = m_s[1].pc; m_s[1] = bub;
    end else begin
      m_s[1] = m_s[0];
      m_s[1].br = br;
      m_s[0] = '{pc: m_pc, instr: imem(m_pc), pred: tk, br: 1'b0, valid: 1'b1};
      m_pc = tgt;
    end
  endtask

  task automatic chk_model();
    chk("rnd.addr", bus.icache_addr, m_pc);
    chk("rnd.pc1",  bus.instructionPC_1, m_pc);
    chk("rnd.ren",  {31'd0, bus.icache_ren}, {31'd0, m_ren});
    chk("rnd.v2",   {31'd0, bus.valid_2}, {31'd0, m_s[0].valid});
    chk("rnd.instr2", bus.instr_2, m_s[0].instr);
    if (m_s[0].valid) chk("rnd.pc2", bus.pc_2, m_s[0].pc);
    chk("rnd.v3",   {31'd0, bus.valid_3}, {31'd0, m_s[1].valid});
    if (m_s[1].valid) chk("rnd.pc3", bus.instructionPC_3, m_s[1].pc);
    chk("rnd.pt3",  {31'd0, bus.prev_taken_3}, {31'd0, m_s[1].pred & m_s[1].valid});
    chk("rnd.ib3",  {31'd0, bus.is_branchInst_3}, {31'd0, m_s[1].br & m_s[1].valid});
  endtask

  initial begin
    tv[0]  = '{0,0,0,0,0, 32'h4,        32'h4,        1, 32'h0,        0, 32'h0,   0, 0};
    tv[1]  = '{0,0,0,0,0, 32'h8,        32'h8,        1, 32'h4,        1, 32'h0,   0, 0};
    tv[2]  = '{0,0,0,1,0, 32'h40,       32'h40,       1, 32'h8,        1, 32'h4,   0, 0};
    tv[3]  = '{0,0,0,0,1, 32'h44,       32'h44,       1, 32'h40,       1, 32'h8,   1, 1};
    tv[4]  = '{0,0,1,0,1, 32'h100,      32'h100,      0, 32'h0,        0, 32'h0,   0, 0};
    tv[5]  = '{0,0,0,0,0, 32'h104,      32'h104,      1, 32'h100,      0, 32'h0,   0, 0};
    tv[6]  = '{0,0,0,0,0, 32'h108,      32'h108,      1, 32'h104,      1, 32'h100, 0, 0};
    tv[7]  = '{0,0,1,0,0, 32'h1C,       32'h1C,       0, 32'h0,        0, 32'h0,   0, 0};
    tv[8]  = '{0,0,0,0,0, 32'h20,       32'h20,       1, 32'h1C,       0, 32'h0,   0, 0};
    tv[9]  = '{0,1,0,0,0, 32'h24,       32'h20,       1, 32'h1C,       0, 32'h0,   0, 0};
    tv[10] = '{0,0,0,0,0, 32'h24,       32'h24,       1, 32'h20,       1, 32'h1C,  0, 0};
    tv[11] = '{0,1,1,0,0, 32'h200,      32'h200,      0, 32'h0,        0, 32'h0,   0, 0};
    tv[12] = '{0,0,0,0,0, 32'h204,      32'h204,      1, 32'h200,      0, 32'h0,   0, 0};
    tv[13] = '{1,0,1,0,0, 32'h300,      32'h204,      1, 32'h200,      0, 32'h0,   0, 0};
    tv[14] = '{1,0,1,0,0, 32'h300,      32'h204,      1, 32'h200,      0, 32'h0,   0, 0};
    tv[15] = '{1,0,1,0,0, 32'h300,      32'h204,      1, 32'h200,      0, 32'h0,   0, 0};
    tv[16] = '{0,0,1,0,0, 32'h300,      32'h300,      0, 32'h0,        0, 32'h0,   0, 0};
    tv[17] = '{0,0,1,0,0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 32'h0,      0, 32'h0,   0, 0};
    tv[18] = '{0,0,0,0,0, 32'h0,        32'h0,        1, 32'hFFFF_FFFC, 0, 32'h0,  0, 0};
    tv[19] = '{0,0,0,1,1, 32'h4,        32'h4,        1, 32'h0,        1, 32'hFFFF_FFFC, 0, 1};

    // Power-on reset
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("por");

    // Directed vector table
    rst_n = 1'b1;
    for (int i = 0; i < NV; i++) begin
      drive(tv[i].mem, tv[i].lu, tv[i].fl, tv[i].tk, tv[i].br, tv[i].tgt);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.pc", i),  bus.icache_addr, tv[i].e_pc);
      chk($sformatf("v%0d.ren", i), {31'd0, bus.icache_ren}, 32'd1);
      chk($sformatf("v%0d.v2", i),  {31'd0, bus.valid_2}, {31'd0, tv[i].e_v2});
      chk($sformatf("v%0d.instr2", i), bus.instr_2, tv[i].e_v2 ? imem(tv[i].e_pc2) : NOP_INSTR);
      if (tv[i].e_v2) chk($sformatf("v%0d.pc2", i), bus.pc_2, tv[i].e_pc2);
      chk($sformatf("v%0d.v3", i),  {31'd0, bus.valid_3}, {31'd0, tv[i].e_v3});
      if (tv[i].e_v3) chk($sformatf("v%0d.pc3", i), bus.instructionPC_3, tv[i].e_pc3);
      chk($sformatf("v%0d.pt3", i), {31'd0, bus.prev_taken_3}, {31'd0, tv[i].e_pt});
      chk($sformatf("v%0d.ib3", i), {31'd0, bus.is_branchInst_3}, {31'd0, tv[i].e_ib});
    end

    // Reset mid-operation overrides stall and flush
    drive(1, 1, 1, 1, 1, 32'h500);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_state("midrst");

    // Randomized run against the reference model
    m_reset();
    rst_n = 1'b1;
    for (int c = 0; c < 600; c++) begin
      logic r_rst, r_mem, r_lu, r_fl, r_tk, r_br;
      logic [31:0] r_tgt;
      r_rst = ($urandom_range(0, 79) == 0);
      r_mem = ($urandom_range(0, 7) == 0);
      r_lu  = ($urandom_range(0, 7) == 0);
      r_fl  = ($urandom_range(0, 9) == 0);
      r_tk  = ($urandom_range(0, 3) == 0);
      r_br  = $urandom_range(0, 1) == 1;
      r_tgt = (r_tk || r_fl) ? {$urandom(), 2'b00} : m_pc + 32'd4;
      rst_n = ~r_rst;
      drive(r_mem, r_lu, r_fl, r_tk, r_br, r_tgt);
      m_step(r_rst, r_mem, r_lu, r_fl, r_tk, r_br, r_tgt);
      @(posedge clk);
      #1;
      chk_model();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
